// File: rtl/rob_xcpt_handler.sv
// rtl/rob_xcpt_handler.sv - commit-side exception entry/return sequencer for the reorder buffer
package rob_xcpt_pkg;
    localparam int XCPT_PC_W = 32;

    typedef enum logic [2:0] {
        XCPT_ITLB_MISS        = 3'd0,
        XCPT_FETCH_BUS_ERROR  = 3'd1,
        XCPT_ILLEGAL_INSTR    = 3'd2,
        XCPT_OVERFLOW         = 3'd3,
        XCPT_CACHE_ADDR_FAULT = 3'd4,
        XCPT_DTLB_MISS        = 3'd5,
        XCPT_CACHE_BUS_ERROR  = 3'd6
    } xcpt_type_t;

    typedef struct packed {
        logic                 valid;
        xcpt_type_t           xcpt_type;
        logic [XCPT_PC_W-1:0] addr_val;
        logic [XCPT_PC_W-1:0] pc;
    } reorder_buffer_xcpt_info_t;
endpackage

module rob_xcpt_handler
    import rob_xcpt_pkg::*;
#(
    parameter int                  PC_WIDTH        = 32,
    parameter int                  ROB_IDX_WIDTH   = 3,
    parameter logic [PC_WIDTH-1:0] XCPT_HANDLER_PC = 32'h0000_2000,
    parameter int                  FLUSH_CYCLES    = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      commit_valid,
    input  logic [ROB_IDX_WIDTH-1:0]  commit_rob_idx,
    input  logic [PC_WIDTH-1:0]       commit_pc,
    input  logic                      commit_is_iret,
    input  reorder_buffer_xcpt_info_t commit_xcpt_info,
    output logic                      commit_stall,
    output logic                      xcpt_taken,
    output logic                      flush_pipeline,
    output logic                      fetch_redirect_valid,
    output logic [PC_WIDTH-1:0]       fetch_redirect_pc,
    input  logic                      fetch_redirect_ack,
    output logic                      priv_mode,
    output logic [PC_WIDTH-1:0]       rm0_xcpt_pc,
    output logic [PC_WIDTH-1:0]       rm1_xcpt_addr,
    output xcpt_type_t                rm2_xcpt_type,
    output logic [ROB_IDX_WIDTH-1:0]  rm2_xcpt_rob_idx,
    output logic                      fatal_error,
    output logic [7:0]                xcpt_count
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        REDIRECT,
        HANDLER,
        RETURN,
        FATAL
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   flush_cnt, flush_cnt_next;
    logic               accept;
    logic               enter;
    xcpt_type_t         cap_type;
    logic [PC_WIDTH-1:0] cap_pc;
    logic [PC_WIDTH-1:0] cap_addr;

    // Outputs are registered from state_next, so stall here reflects the current state.
    always_comb begin
        accept         = commit_valid && !commit_stall;
        state_next     = state;
        flush_cnt_next = flush_cnt;
        enter          = 1'b0;
        case (state)
            IDLE: begin
                if (accept && (commit_xcpt_info.valid || commit_is_iret)) begin
                    enter          = 1'b1;
                    state_next     = FLUSH;
                    flush_cnt_next = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) state_next = REDIRECT;
                else                 flush_cnt_next = flush_cnt - 1'b1;
            end
            REDIRECT: begin
                if (fetch_redirect_ack) state_next = HANDLER;
            end
            HANDLER: begin
                if (accept) begin
                    if (commit_xcpt_info.valid) state_next = FATAL;
                    else if (commit_is_iret)    state_next = RETURN;
                end
            end
            RETURN: begin
                if (fetch_redirect_ack) state_next = IDLE;
            end
            FATAL:   state_next = FATAL;
            default: state_next = IDLE;
        endcase
    end

    // An iret with no exception record enters as illegal_instr at its own PC.
    always_comb begin
        cap_type = XCPT_ILLEGAL_INSTR;
        cap_pc   = commit_pc;
        cap_addr = '0;
        if (commit_xcpt_info.valid) begin
            cap_type = commit_xcpt_info.xcpt_type;
            cap_pc   = PC_WIDTH'(commit_xcpt_info.pc);
            case (commit_xcpt_info.xcpt_type)
                XCPT_ITLB_MISS, XCPT_FETCH_BUS_ERROR, XCPT_CACHE_ADDR_FAULT,
                XCPT_DTLB_MISS, XCPT_CACHE_BUS_ERROR:
                    cap_addr = PC_WIDTH'(commit_xcpt_info.addr_val);
                default: cap_addr = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state                <= IDLE;
            flush_cnt            <= '0;
            commit_stall         <= 1'b0;
            xcpt_taken           <= 1'b0;
            flush_pipeline       <= 1'b0;
            fetch_redirect_valid <= 1'b0;
            fetch_redirect_pc    <= '0;
            priv_mode            <= 1'b0;
            rm0_xcpt_pc          <= '0;
            rm1_xcpt_addr        <= '0;
            rm2_xcpt_type        <= XCPT_ITLB_MISS;
            rm2_xcpt_rob_idx     <= '0;
            fatal_error          <= 1'b0;
            xcpt_count           <= '0;
        end else begin
            state                <= state_next;
            flush_cnt            <= flush_cnt_next;
            commit_stall         <= (state_next == FLUSH) || (state_next == REDIRECT) ||
                                    (state_next == RETURN) || (state_next == FATAL);
            xcpt_taken           <= enter;
            flush_pipeline       <= (state_next == FLUSH) || (state_next == RETURN);
            fetch_redirect_valid <= (state_next == REDIRECT) || (state_next == RETURN);
            fatal_error          <= (state_next == FATAL);
            if (state_next == REDIRECT)    fetch_redirect_pc <= XCPT_HANDLER_PC;
            else if (state_next == RETURN) fetch_redirect_pc <= rm0_xcpt_pc;
            if (enter) begin
                rm0_xcpt_pc      <= cap_pc;
                rm1_xcpt_addr    <= cap_addr;
                rm2_xcpt_type    <= cap_type;
                rm2_xcpt_rob_idx <= commit_rob_idx;
                priv_mode        <= 1'b1;
                if (xcpt_count != 8'hFF) xcpt_count <= xcpt_count + 8'd1;
            end else if ((state == RETURN) && (state_next == IDLE)) begin
                priv_mode <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rob_xcpt_handler.sv
// tb/tb_rob_xcpt_handler.sv - directed and randomized checks of rob_xcpt_handler against a mode-level model
module tb_rob_xcpt_handler;
    import rob_xcpt_pkg::*;

    localparam int          F   = 2;
    localparam logic [31:0] HPC = 32'h0000_2000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic commit_valid = 1'b0;
    logic [2:0] commit_rob_idx = '0;
    logic [31:0] commit_pc = '0;
    logic commit_is_iret = 1'b0;
    reorder_buffer_xcpt_info_t commit_xcpt_info = '0;
    logic fetch_redirect_ack = 1'b0;
    logic commit_stall, xcpt_taken, flush_pipeline, fetch_redirect_valid, priv_mode, fatal_error;
    logic [31:0] fetch_redirect_pc, rm0_xcpt_pc, rm1_xcpt_addr;
    xcpt_type_t rm2_xcpt_type;
    logic [2:0] rm2_xcpt_rob_idx;
    logic [7:0] xcpt_count;

    int n_vec = 0;
    int n_err = 0;

    rob_xcpt_handler #(.PC_WIDTH(32), .ROB_IDX_WIDTH(3), .XCPT_HANDLER_PC(HPC), .FLUSH_CYCLES(F)) dut (
        .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
        .commit_pc(commit_pc), .commit_is_iret(commit_is_iret), .commit_xcpt_info(commit_xcpt_info),
        .commit_stall(commit_stall), .xcpt_taken(xcpt_taken), .flush_pipeline(flush_pipeline),
        .fetch_redirect_valid(fetch_redirect_valid), .fetch_redirect_pc(fetch_redirect_pc),
        .fetch_redirect_ack(fetch_redirect_ack), .priv_mode(priv_mode), .rm0_xcpt_pc(rm0_xcpt_pc),
        .rm1_xcpt_addr(rm1_xcpt_addr), .rm2_xcpt_type(rm2_xcpt_type), .rm2_xcpt_rob_idx(rm2_xcpt_rob_idx),
        .fatal_error(fatal_error), .xcpt_count(xcpt_count)
    );

    always #5 clock = ~clock;

    // Model: supervisor flag, flush cycles still owed, and an outstanding redirect target.
    bit          m_priv, m_fatal, m_pend, m_ret, m_taken;
    int          m_flush_left;
    logic [31:0] m_target, m_rm0, m_rm1;
    xcpt_type_t  m_rm2t;
    logic [2:0]  m_rm2i;
    logic [7:0]  m_count;

    task automatic model_enter(input xcpt_type_t t, input logic [31:0] pc, input logic [31:0] addr);
        bit keeps_addr;
        keeps_addr = (t == XCPT_ITLB_MISS) || (t == XCPT_FETCH_BUS_ERROR) || (t == XCPT_CACHE_ADDR_FAULT) ||
                     (t == XCPT_DTLB_MISS) || (t == XCPT_CACHE_BUS_ERROR);
        m_rm0 = pc;
        m_rm1 = keeps_addr ? addr : 32'h0;
        m_rm2t = t;
        m_rm2i = commit_rob_idx;
        m_taken = 1;
        m_priv = 1;
        m_flush_left = F;
        if (m_count != 8'hFF) m_count = m_count + 8'd1;
    endtask

    task automatic model_edge();
        m_taken = 0;
        if (!reset) begin
            m_priv = 0; m_fatal = 0; m_pend = 0; m_ret = 0; m_flush_left = 0;
            m_target = 0; m_rm0 = 0; m_rm1 = 0; m_rm2t = XCPT_ITLB_MISS; m_rm2i = 0; m_count = 0;
        end else if (m_fatal) begin
            m_fatal = 1;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
            if (m_flush_left == 0) begin
                m_pend = 1;
                m_target = HPC;
            end
        end else if (m_pend) begin
            if (fetch_redirect_ack) begin
                m_pend = 0;
                if (m_ret) begin
                    m_ret = 0;
                    m_priv = 0;
                end
            end
        end else if (commit_valid) begin
            if (commit_xcpt_info.valid) begin
                if (m_priv) m_fatal = 1;
                else model_enter(commit_xcpt_info.xcpt_type, commit_xcpt_info.pc, commit_xcpt_info.addr_val);
            end else if (commit_is_iret) begin
                if (m_priv) begin
                    m_ret = 1;
                    m_pend = 1;
                    m_target = m_rm0;
                end else begin
                    model_enter(XCPT_ILLEGAL_INSTR, commit_pc, 32'h0);
                end
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic set_xcpt(input xcpt_type_t t, input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] idx);
        commit_valid = 1'b1;
        commit_is_iret = 1'b0;
        commit_rob_idx = idx;
        commit_pc = pc;
        commit_xcpt_info.valid = 1'b1;
        commit_xcpt_info.xcpt_type = t;
        commit_xcpt_info.pc = pc;
        commit_xcpt_info.addr_val = addr;
    endtask

    task automatic set_iret(input logic [31:0] pc, input logic [2:0] idx);
        commit_valid = 1'b1;
        commit_is_iret = 1'b1;
        commit_rob_idx = idx;
        commit_pc = pc;
        commit_xcpt_info = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        commit_valid = 1'b0;
        fetch_redirect_ack = 1'b0;
        cycle();
        n_vec++; if ({commit_stall, xcpt_taken, flush_pipeline, fetch_redirect_valid, fatal_error, priv_mode} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 000000", {commit_stall, xcpt_taken, flush_pipeline, fetch_redirect_valid, fatal_error, priv_mode}); end
        n_vec++; if ({fetch_redirect_pc, rm0_xcpt_pc, rm1_xcpt_addr, rm2_xcpt_type, rm2_xcpt_rob_idx, xcpt_count} !== '0) begin
            n_err++; $display("FAIL reset_regs got pc=%h rm0=%h rm1=%h t=%0d i=%0d cnt=%0d want all 0",
                fetch_redirect_pc, rm0_xcpt_pc, rm1_xcpt_addr, rm2_xcpt_type, rm2_xcpt_rob_idx, xcpt_count); end
        reset = 1'b1;
    endtask

    task automatic test_dtlb_entry();
        fetch_redirect_ack = 1'b1;
        set_xcpt(XCPT_DTLB_MISS, 32'h100, 32'hBEEF, 3'd5);
        cycle();
        commit_valid = 1'b0;
        n_vec++; if ({xcpt_taken, commit_stall, flush_pipeline, priv_mode, fetch_redirect_valid} !== 5'b11110) begin
            n_err++; $display("FAIL dtlb_n1_flags got %b want 11110", {xcpt_taken, commit_stall, flush_pipeline, priv_mode, fetch_redirect_valid}); end
        n_vec++; if (rm0_xcpt_pc !== 32'h100 || rm1_xcpt_addr !== 32'hBEEF || rm2_xcpt_type !== XCPT_DTLB_MISS || rm2_xcpt_rob_idx !== 3'd5) begin
            n_err++; $display("FAIL dtlb_rm got rm0=%h rm1=%h t=%0d i=%0d want 100 beef 5 5", rm0_xcpt_pc, rm1_xcpt_addr, rm2_xcpt_type, rm2_xcpt_rob_idx); end
        cycle();
        n_vec++; if ({xcpt_taken, flush_pipeline, fetch_redirect_valid} !== 3'b010) begin
            n_err++; $display("FAIL dtlb_n2 got %b want 010", {xcpt_taken, flush_pipeline, fetch_redirect_valid}); end
        cycle();
        n_vec++; if ({flush_pipeline, fetch_redirect_valid, commit_stall} !== 3'b011 || fetch_redirect_pc !== HPC) begin
            n_err++; $display("FAIL dtlb_n3 got fl/v/st=%b pc=%h want 011 2000", {flush_pipeline, fetch_redirect_valid, commit_stall}, fetch_redirect_pc); end
        cycle();
        n_vec++; if ({fetch_redirect_valid, commit_stall, priv_mode} !== 3'b001) begin
            n_err++; $display("FAIL dtlb_ack got v/st/priv=%b want 001", {fetch_redirect_valid, commit_stall, priv_mode}); end
    endtask

    task automatic test_iret_return(input logic [31:0] exp_pc);
        fetch_redirect_ack = 1'b0;
        set_iret(32'h7777, 3'd1);
        cycle();
        commit_valid = 1'b0;
        n_vec++; if ({flush_pipeline, fetch_redirect_valid, commit_stall, priv_mode} !== 4'b1111 || fetch_redirect_pc !== exp_pc) begin
            n_err++; $display("FAIL iret_ret got fl/v/st/priv=%b pc=%h want 1111 %h",
                {flush_pipeline, fetch_redirect_valid, commit_stall, priv_mode}, fetch_redirect_pc, exp_pc); end
        fetch_redirect_ack = 1'b1;
        cycle();
        n_vec++; if ({flush_pipeline, fetch_redirect_valid, commit_stall, priv_mode} !== 4'b0000) begin
            n_err++; $display("FAIL iret_done got fl/v/st/priv=%b want 0000", {flush_pipeline, fetch_redirect_valid, commit_stall, priv_mode}); end
    endtask

    task automatic test_overflow_delayed_ack();
        fetch_redirect_ack = 1'b0;
        set_xcpt(XCPT_OVERFLOW, 32'h300, 32'h55, 3'd2);
        cycle();
        n_vec++; if (rm1_xcpt_addr !== 32'h0 || rm2_xcpt_type !== XCPT_OVERFLOW || rm0_xcpt_pc !== 32'h300) begin
            n_err++; $display("FAIL ovf_rm got rm0=%h rm1=%h t=%0d want 300 0 3", rm0_xcpt_pc, rm1_xcpt_addr, rm2_xcpt_type); end
        set_xcpt(XCPT_CACHE_BUS_ERROR, 32'h999, 32'h1, 3'd6);
        cycle();
        cycle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_vec++; if ({fetch_redirect_valid, commit_stall} !== 2'b11 || fetch_redirect_pc !== HPC) begin
                n_err++; $display("FAIL ovf_hold%0d got v/st=%b pc=%h want 11 2000", k, {fetch_redirect_valid, commit_stall}, fetch_redirect_pc); end
        end
        fetch_redirect_ack = 1'b1;
        commit_valid = 1'b0;
        cycle();
        n_vec++; if ({fetch_redirect_valid, commit_stall} !== 2'b00 || xcpt_count !== 8'd2) begin
            n_err++; $display("FAIL ovf_ack got v/st=%b cnt=%0d want 00 2", {fetch_redirect_valid, commit_stall}, xcpt_count); end
    endtask

    task automatic test_iret_idle();
        fetch_redirect_ack = 1'b1;
        set_iret(32'h40, 3'd4);
        cycle();
        commit_valid = 1'b0;
        n_vec++; if (xcpt_taken !== 1'b1 || rm0_xcpt_pc !== 32'h40 || rm1_xcpt_addr !== 32'h0 ||
                     rm2_xcpt_type !== XCPT_ILLEGAL_INSTR || xcpt_count !== 8'd3) begin
            n_err++; $display("FAIL iret_idle got tk=%b rm0=%h rm1=%h t=%0d cnt=%0d want 1 40 0 2 3",
                xcpt_taken, rm0_xcpt_pc, rm1_xcpt_addr, rm2_xcpt_type, xcpt_count); end
        cycle(); cycle(); cycle();
        n_vec++; if ({commit_stall, priv_mode} !== 2'b01) begin
            n_err++; $display("FAIL iret_idle_handler got st/priv=%b want 01", {commit_stall, priv_mode}); end
    endtask

    task automatic test_double_fault();
        set_xcpt(XCPT_DTLB_MISS, 32'h999, 32'h1234, 3'd7);
        cycle();
        for (int k = 0; k < 4; k++) begin
            n_vec++; if ({fatal_error, commit_stall, flush_pipeline, fetch_redirect_valid, xcpt_taken} !== 5'b11000 ||
                         rm0_xcpt_pc !== 32'h40 || rm1_xcpt_addr !== 32'h0 || rm2_xcpt_type !== XCPT_ILLEGAL_INSTR ||
                         rm2_xcpt_rob_idx !== 3'd4 || xcpt_count !== 8'd3) begin
                n_err++; $display("FAIL fatal%0d got f/st/fl/v/tk=%b rm0=%h rm1=%h t=%0d i=%0d cnt=%0d want 11000 40 0 2 4 3", k,
                    {fatal_error, commit_stall, flush_pipeline, fetch_redirect_valid, xcpt_taken},
                    rm0_xcpt_pc, rm1_xcpt_addr, rm2_xcpt_type, rm2_xcpt_rob_idx, xcpt_count); end
            if (k[0]) set_iret(32'h44, 3'd0); else set_xcpt(XCPT_ITLB_MISS, 32'h8, 32'h9, 3'd1);
            cycle();
        end
        commit_valid = 1'b0;
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        n_vec++; if ({fatal_error, commit_stall, priv_mode, xcpt_count, rm0_xcpt_pc} !== '0) begin
            n_err++; $display("FAIL fatal_reset got f=%b st=%b priv=%b cnt=%0d rm0=%h want all 0",
                fatal_error, commit_stall, priv_mode, xcpt_count, rm0_xcpt_pc); end
    endtask

    task automatic test_saturation_and_reset_in_redirect();
        for (int e = 1; e <= 256; e++) begin
            fetch_redirect_ack = (e != 256);
            set_xcpt(XCPT_CACHE_ADDR_FAULT, 32'h500 + e, e, 3'(e));
            cycle();
            commit_valid = 1'b0;
            if (e >= 254) begin
                n_vec++; if (xcpt_count !== ((e > 255) ? 8'hFF : 8'(e))) begin
                    n_err++; $display("FAIL sat_count%0d got %0d want %0d", e, xcpt_count, (e > 255) ? 255 : e); end
            end
            cycle(); cycle();
            if (e != 256) begin
                cycle();
                set_iret(32'h0, 3'd0);
                cycle();
                commit_valid = 1'b0;
                cycle();
            end
        end
        n_vec++; if (fetch_redirect_valid !== 1'b1) begin
            n_err++; $display("FAIL sat_in_redirect got v=%b want 1", fetch_redirect_valid); end
        reset = 1'b0;
        fetch_redirect_ack = 1'b1;
        cycle();
        reset = 1'b1;
        n_vec++; if ({commit_stall, xcpt_taken, flush_pipeline, fetch_redirect_valid, fatal_error, priv_mode, fetch_redirect_pc,
                      rm0_xcpt_pc, rm1_xcpt_addr, rm2_xcpt_type, rm2_xcpt_rob_idx, xcpt_count} !== '0) begin
            n_err++; $display("FAIL redirect_reset got st=%b v=%b priv=%b pc=%h cnt=%0d want all 0",
                commit_stall, fetch_redirect_valid, priv_mode, fetch_redirect_pc, xcpt_count); end
    endtask

    task automatic test_random();
        logic [140:0] exp_v, got_v;
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            commit_valid = $urandom_range(0, 1);
            commit_rob_idx = 3'($urandom);
            commit_pc = $urandom;
            commit_is_iret = ($urandom_range(0, 3) == 0);
            commit_xcpt_info.valid = ($urandom_range(0, 7) == 0);
            commit_xcpt_info.xcpt_type = xcpt_type_t'($urandom_range(0, 6));
            commit_xcpt_info.pc = $urandom;
            commit_xcpt_info.addr_val = $urandom;
            fetch_redirect_ack = $urandom_range(0, 1);
            cycle();
            exp_v = {m_fatal || (m_flush_left > 0) || m_pend, m_taken, (m_flush_left > 0) || (m_pend && m_ret), m_pend,
                     m_fatal, m_priv, m_rm0, m_rm1, m_rm2t, m_rm2i, m_count, (m_pend ? m_target : 32'h0)};
            got_v = {commit_stall, xcpt_taken, flush_pipeline, fetch_redirect_valid, fatal_error, priv_mode,
                     rm0_xcpt_pc, rm1_xcpt_addr, rm2_xcpt_type, rm2_xcpt_rob_idx, xcpt_count,
                     (fetch_redirect_valid ? fetch_redirect_pc : 32'h0)};
            n_vec++; if (got_v !== exp_v) begin
                n_err++; $display("FAIL random_c%0d got %h want %h", c, got_v, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_dtlb_entry();
        test_iret_return(32'h100);
        test_overflow_delayed_ack();
        test_iret_return(32'h300);
        test_iret_idle();
        test_double_fault();
        test_saturation_and_reset_in_redirect();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rob_xcpt_handler.md
# rob_xcpt_handler

Commit-side consumer of the per-entry exception records that writeback produces for the reorder buffer. When the RoB head retires an entry whose exception record is valid, the block latches the exception into the privileged registers and flushes the pipeline. It then redirects fetch to the handler and runs the core in supervisor mode until an `iret` retires, after which it returns fetch to the faulting PC. It sits between the reorder buffer commit port, the fetch stage redirect port and the pipeline flush network.

## Interface
- `PC_WIDTH`, 32, width of PC and faulting address.
- `ROB_IDX_WIDTH`, 3, width of RoB entry index.
- `XCPT_HANDLER_PC`, 32'h0000_2000, fetch target on exception entry.
- `FLUSH_CYCLES`, 2, cycles `flush_pipeline` is held on exception entry (≥1).

Ports:
- `clock` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-low; state resets when sampled 0 on `clock` rising edge.
- `commit_valid` in 1: RoB head retires this cycle.
- `commit_rob_idx` in ROB_IDX_WIDTH: index of retiring entry.
- `commit_pc` in PC_WIDTH: PC of retiring entry.
- `commit_is_iret` in 1: retiring entry is `iret`.
- `commit_xcpt_info` in reorder_buffer_xcpt_info_t: valid, xcpt_type, addr_val, pc of retiring entry.
- `commit_stall` out 1: RoB must not retire while 1.
- `xcpt_taken` out 1: one-cycle pulse on exception acceptance.
- `flush_pipeline` out 1: kill all in-flight instructions.
- `fetch_redirect_valid` out 1, `fetch_redirect_pc` out PC_WIDTH, `fetch_redirect_ack` in 1: valid/ack redirect handshake.
- `priv_mode` out 1: 1 = supervisor.
- `rm0_xcpt_pc` out PC_WIDTH, `rm1_xcpt_addr` out PC_WIDTH, `rm2_xcpt_type` out xcpt_type_t, `rm2_xcpt_rob_idx` out ROB_IDX_WIDTH: captured exception state.
- `fatal_error` out 1: sticky double-fault indication.
- `xcpt_count` out 8: exceptions accepted, saturating.

## Operation
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN, FATAL.
- A commit is accepted only when `commit_valid`=1 and `commit_stall`=0. `commit_stall`=1 in FLUSH, REDIRECT, RETURN and FATAL.
- IDLE, accepted commit with `commit_xcpt_info.valid`=1: latch rm0 ← info.pc, rm1 ← info.addr_val, rm2 ← info.xcpt_type and `commit_rob_idx`. Pulse `xcpt_taken`, increment `xcpt_count`, set `priv_mode`=1, go to FLUSH.
- rm1 is loaded only for iTlb_miss, fetch_bus_error, cache_addr_fault, dTlb_miss and cache_bus_error. For illegal_instr and overflow, rm1 ← 0.
- IDLE, accepted `iret` without an exception: treated as an illegal_instr exception with rm0 ← `commit_pc` and rm1 ← 0; entry is the same as above.
- FLUSH: `flush_pipeline`=1 for exactly FLUSH_CYCLES cycles using a down-counter, then go to REDIRECT.
- REDIRECT: `fetch_redirect_valid`=1 with `fetch_redirect_pc`=XCPT_HANDLER_PC, held until a cycle with `fetch_redirect_ack`=1. Then go to HANDLER.
- HANDLER: commits flow normally.
  - An accepted commit with `commit_xcpt_info.valid`=1 is a double fault: go to FATAL, set `fatal_error`=1, keep rm0–rm2 unchanged.
  - An accepted `iret` without an exception: go to RETURN.
- RETURN: `flush_pipeline`=1 and `fetch_redirect_valid`=1 with `fetch_redirect_pc`=rm0 until `fetch_redirect_ack`. On ack, `priv_mode` ← 0 and go to IDLE.
- FATAL: held until reset; `commit_stall`=1, all redirect and flush outputs 0.
- If exception valid and `commit_is_iret` are both set on one commit, the exception wins.
- `xcpt_count` saturates at 8'hFF.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `commit_stall`, `xcpt_taken`, `flush_pipeline`, `fetch_redirect_valid`, `fatal_error` and `priv_mode` all 0; `fetch_redirect_pc`, rm0, rm1, rm2 type/index and `xcpt_count` all 0.
- Reset mid-operation, in any state, returns to IDLE within one edge and aborts any pending redirect.
- Exception commit in cycle N:
  - cycle N+1: `xcpt_taken`=1, `commit_stall`=1, `flush_pipeline`=1, rm0–rm2 valid.
  - cycles N+1..N+FLUSH_CYCLES: flush held.
  - cycle N+FLUSH_CYCLES+1: `fetch_redirect_valid` rises.
- Redirect ack sampled in cycle M: `fetch_redirect_valid` and `commit_stall` are 0 in M+1. An ack present in the same cycle the redirect first asserts is honoured.
- `fetch_redirect_ack` is ignored outside REDIRECT and RETURN.
- `fetch_redirect_pc` and `fetch_redirect_valid` are stable while waiting for ack.

## Test plan
- Reset, then a dTlb_miss commit with pc=0x100 and addr_val=0xBEEF, ack held 1 -> `xcpt_taken` pulse at N+1; flush in N+1..N+2; redirect to 0x2000 at N+3; rm0=0x100, rm1=0xBEEF; `priv_mode`=1.
- Overflow exception commit with addr_val=0x55 -> rm1=0, rm2 type=overflow; ack delayed 4 cycles -> redirect outputs held stable for 4 cycles and `commit_stall`=1 throughout.
- From HANDLER, `iret` commit -> flush and redirect to rm0=0x100; on ack `priv_mode`=0 and state IDLE.
- `iret` in IDLE with `commit_pc`=0x40 -> illegal_instr exception, rm0=0x40.
- Exception commit in HANDLER -> `fatal_error`=1, `commit_stall`=1 sticky, rm0–rm2 unchanged; reset clears everything.
- 256 accepted exceptions -> `xcpt_count`=0xFF; `reset`=0 asserted during REDIRECT -> all outputs at reset values on the next edge.
